// File: rtl/road_scroll_engine.sv
// Road generator: circular line buffer of {centre, half-width} per screen row, scripted curves,
// distance-driven difficulty, edge lookup for the pixel mux and car/verge collision with restart.
module road_scroll_engine #(
    parameter int unsigned ROWS         = 480,
    parameter int unsigned X_CENTER     = 464,
    parameter int unsigned HALF_W0      = 50,
    parameter int unsigned HALF_W_MIN   = 20,
    parameter int unsigned X_MIN        = 160,
    parameter int unsigned X_MAX        = 780,
    parameter int unsigned SCROLL_STEP  = 2,
    parameter int unsigned LEVEL_ROWS   = 512,
    parameter int unsigned CRASH_FRAMES = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        pause,
    input  logic [9:0]  vCount,
    input  logic [9:0]  car_row,
    input  logic [9:0]  car_x_lo,
    input  logic [9:0]  car_x_hi,
    output logic [9:0]  left_edge,
    output logic [9:0]  right_edge,
    output logic        crash,
    output logic        dead,
    output logic [3:0]  level,
    output logic [15:0] distance
);

    localparam int unsigned AW   = $clog2(ROWS);
    localparam int unsigned LvlW = $clog2(LEVEL_ROWS);
    localparam int unsigned CrW  = $clog2(CRASH_FRAMES);

    localparam logic [AW:0]          RowsW   = (AW + 1)'(ROWS);
    localparam logic [9:0]           RowsV   = 10'(ROWS);
    localparam logic [AW-1:0]        LastIdx = AW'(ROWS - 1);
    localparam logic [9:0]           XCenter = 10'(X_CENTER);
    localparam logic [9:0]           Hw0     = 10'(HALF_W0);
    localparam logic [9:0]           HwMin   = 10'(HALF_W_MIN);
    localparam logic [9:0]           HwRange = 10'(HALF_W0 - HALF_W_MIN);
    localparam logic [9:0]           EdgeL0  = 10'(X_CENTER - HALF_W0);
    localparam logic [9:0]           EdgeR0  = 10'(X_CENTER + HALF_W0);
    localparam logic signed [10:0]   XMinS   = 11'(X_MIN);
    localparam logic signed [10:0]   XMaxS   = 11'(X_MAX);
    localparam logic signed [10:0]   XCentS  = 11'(X_CENTER);
    localparam logic [3:0]           Step    = 4'(SCROLL_STEP);
    localparam logic [LvlW-1:0]      LvlLast = LvlW'(LEVEL_ROWS - 1);
    localparam logic [CrW-1:0]       CrLast  = CrW'(CRASH_FRAMES - 1);

    typedef enum logic [1:0] {StFill, StRun, StGen, StCrash} state_e;

    state_e state_q, state_d;

    logic [AW-1:0]      wp_q, fill_cnt_q;
    logic signed [10:0] center_q;
    logic [1:0]         ptr_q;
    logic [7:0]         rows_left_q;
    logic [1:0]         delta_q;
    logic [3:0]         gcnt_q;
    logic [LvlW-1:0]    lvl_cnt_q;
    logic [CrW-1:0]     crash_cnt_q;
    logic [9:0]         row_q;

    logic [19:0] mem [ROWS];
    logic        mem_we;
    logic [AW-1:0] mem_waddr;
    logic [19:0] mem_wdata;

    // Lookup address: screen row offset from the newest row, wrapped modulo ROWS.
    logic [9:0]    row_sel;
    logic [AW:0]   addr_sum;
    logic [AW-1:0] rd_addr;
    logic [19:0]   rd_entry;
    logic [9:0]    left_rd, right_rd;

    always_comb begin
        row_sel  = (vCount >= RowsV) ? 10'd0 : vCount;
        addr_sum = {1'b0, wp_q} + {1'b0, row_sel[AW-1:0]};
        rd_addr  = (addr_sum >= RowsW) ? AW'(addr_sum - RowsW) : addr_sum[AW-1:0];
        rd_entry = mem[rd_addr];
        left_rd  = rd_entry[19:10] - rd_entry[9:0];
        right_rd = rd_entry[19:10] + rd_entry[9:0];
    end

    // Current half-width from level, floored at HALF_W_MIN.
    logic [9:0] hw_dec, hw;
    always_comb begin
        hw_dec = {5'd0, level - 4'd1, 1'b0};
        hw     = (hw_dec > HwRange) ? HwMin : (Hw0 - hw_dec);
    end

    // Script table: {delta, rows} entries cycling 0,+1,0,-1.
    logic [1:0] tbl_delta;
    logic [7:0] tbl_rows;
    always_comb begin
        tbl_delta = 2'b00;
        tbl_rows  = 8'd40;
        unique case (ptr_q)
            2'd0: begin tbl_delta = 2'b00; tbl_rows = 8'd40; end
            2'd1: begin tbl_delta = 2'b01; tbl_rows = 8'd24; end
            2'd2: begin tbl_delta = 2'b00; tbl_rows = 8'd16; end
            2'd3: begin tbl_delta = 2'b11; tbl_rows = 8'd24; end
        endcase
    end

    logic [1:0]         eff_delta;
    logic [2:0]         slope;
    logic signed [10:0] step, center_nxt, center_cl, hw_s, lo_s, hi_s;
    logic               clamp;

    always_comb begin
        eff_delta = (rows_left_q == 8'd0) ? tbl_delta : delta_q;
        slope     = {1'b0, level[3:2]} + 3'd1;
        step      = '0;
        if (eff_delta == 2'b01) begin
            step = signed'({8'd0, slope});
        end else if (eff_delta == 2'b11) begin
            step = -signed'({8'd0, slope});
        end
        center_nxt = center_q + step;
        hw_s       = signed'({1'b0, hw});
        lo_s       = center_nxt - hw_s;
        hi_s       = center_nxt + hw_s;
        clamp      = 1'b0;
        center_cl  = center_nxt;
        if (lo_s < XMinS) begin
            clamp     = 1'b1;
            center_cl = XMinS + hw_s;
        end else if (hi_s > XMaxS) begin
            clamp     = 1'b1;
            center_cl = XMaxS - hw_s;
        end
    end

    logic hit, gen_en;
    logic [AW-1:0] wp_dec;

    always_comb begin
        hit = ((state_q == StRun) || (state_q == StGen)) && !pause && (row_q == car_row) &&
              ((car_x_lo < left_edge) || (car_x_hi > right_edge));
        gen_en = (state_q == StGen) && !pause && !hit;
        wp_dec = (wp_q == '0) ? LastIdx : (wp_q - AW'(1));
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFill:  if (fill_cnt_q == LastIdx) state_d = StRun;
            StRun: begin
                if (hit) state_d = StCrash;
                else if (frame_start && !pause) state_d = StGen;
            end
            StGen: begin
                if (hit) state_d = StCrash;
                else if (gen_en && (gcnt_q == 4'd1)) state_d = StRun;
            end
            StCrash: if (frame_start && (crash_cnt_q == CrLast)) state_d = StFill;
        endcase
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = fill_cnt_q;
        mem_wdata = {XCenter, Hw0};
        if (state_q == StFill) begin
            mem_we = 1'b1;
        end else if (gen_en) begin
            mem_we    = 1'b1;
            mem_waddr = wp_dec;
            mem_wdata = {center_q[9:0], hw};
        end
    end

    // Line buffer is deliberately not reset; FILL initialises it.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StFill;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q        <= '0;
            fill_cnt_q  <= '0;
            center_q    <= XCentS;
            ptr_q       <= '0;
            rows_left_q <= '0;
            delta_q     <= '0;
            gcnt_q      <= '0;
            lvl_cnt_q   <= '0;
            crash_cnt_q <= '0;
            row_q       <= '0;
            left_edge   <= EdgeL0;
            right_edge  <= EdgeR0;
            crash       <= 1'b0;
            dead        <= 1'b0;
            level       <= 4'd1;
            distance    <= '0;
        end else begin
            crash <= hit;
            if (hit) dead <= 1'b1;
            row_q <= row_sel;

            if (state_q == StFill) begin
                left_edge  <= EdgeL0;
                right_edge <= EdgeR0;
                fill_cnt_q <= (fill_cnt_q == LastIdx) ? '0 : (fill_cnt_q + AW'(1));
            end else begin
                left_edge  <= left_rd;
                right_edge <= right_rd;
            end

            if ((state_q == StRun) && (state_d == StGen)) gcnt_q <= Step;

            if (gen_en) begin
                wp_q     <= wp_dec;
                center_q <= center_cl;
                gcnt_q   <= gcnt_q - 4'd1;
                if (distance != 16'hFFFF) distance <= distance + 16'd1;
                if (lvl_cnt_q == LvlLast) begin
                    lvl_cnt_q <= '0;
                    if (level != 4'd15) level <= level + 4'd1;
                end else begin
                    lvl_cnt_q <= lvl_cnt_q + LvlW'(1);
                end
                if (rows_left_q == 8'd0) begin
                    delta_q     <= tbl_delta;
                    rows_left_q <= tbl_rows - 8'd1;
                    ptr_q       <= ptr_q + 2'd1;
                end else begin
                    rows_left_q <= rows_left_q - 8'd1;
                end
                // Hitting a verge cuts the current segment short.
                if (clamp) rows_left_q <= 8'd0;
            end

            if ((state_q == StCrash) && frame_start) begin
                if (crash_cnt_q == CrLast) begin
                    crash_cnt_q <= '0;
                    dead        <= 1'b0;
                    level       <= 4'd1;
                    distance    <= '0;
                    center_q    <= XCentS;
                    ptr_q       <= '0;
                    rows_left_q <= '0;
                    delta_q     <= '0;
                    lvl_cnt_q   <= '0;
                end else begin
                    crash_cnt_q <= crash_cnt_q + CrW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_road_scroll_engine.sv
// Directed self-checking bench for road_scroll_engine with hand-computed road geometry.
module tb_road_scroll_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic        pause;
    logic [9:0]  vCount;
    logic [9:0]  car_row;
    logic [9:0]  car_x_lo;
    logic [9:0]  car_x_hi;
    logic [9:0]  left_edge;
    logic [9:0]  right_edge;
    logic        crash;
    logic        dead;
    logic [3:0]  level;
    logic [15:0] distance;

    int checks = 0;
    int errors = 0;

    road_scroll_engine dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .pause      (pause),
        .vCount     (vCount),
        .car_row    (car_row),
        .car_x_lo   (car_x_lo),
        .car_x_hi   (car_x_hi),
        .left_edge  (left_edge),
        .right_edge (right_edge),
        .crash      (crash),
        .dead       (dead),
        .level      (level),
        .distance   (distance)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic read_row(input int r, output int l, output int rt);
        vCount = 10'(r);
        @(negedge clk);
        l  = int'(left_edge);
        rt = int'(right_edge);
    endtask

    task automatic frame();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        tick(4);
    endtask

    task automatic check_row(input string tag, input int r, input int exp_l, input int exp_r);
        int l, rt;
        read_row(r, l, rt);
        check_eq({tag, "_left"}, l, exp_l);
        check_eq({tag, "_right"}, rt, exp_r);
    endtask

    task automatic sweep_fill(input string tag);
        int l, rt, bad;
        bad = 0;
        for (int r = 0; r < 480; r++) begin
            read_row(r, l, rt);
            if (l != 414 || rt != 514) bad++;
        end
        check_eq(tag, bad, 0);
    endtask

    initial begin
        int crash_cycles;
        int l0, r0;

        rst = 1'b1; frame_start = 1'b0; pause = 1'b0; vCount = '0;
        car_row = 10'd1023; car_x_lo = 10'd460; car_x_hi = 10'd470;
        tick(3);
        rst = 1'b0;
        check_eq("rst_dead", int'(dead), 0);
        check_eq("rst_crash", int'(crash), 0);
        check_eq("rst_level", int'(level), 1);
        check_eq("rst_distance", int'(distance), 0);
        check_eq("rst_left", int'(left_edge), 414);
        check_eq("rst_right", int'(right_edge), 514);

        tick(482);
        sweep_fill("fill_sweep_bad_rows");
        check_eq("fill_dead", int'(dead), 0);
        check_eq("fill_level", int'(level), 1);

        frame();
        check_eq("frame1_distance", int'(distance), 2);
        tick(6);
        check_eq("frame1_distance_hold", int'(distance), 2);
        check_row("frame1_row0", 0, 414, 514);
        check_row("frame1_row1", 1, 414, 514);
        check_row("frame1_row2", 2, 414, 514);

        // 80 rows: +1 segment covered rows generated 41..64, centre now 488.
        repeat (39) frame();
        check_eq("f40_distance", int'(distance), 80);
        check_row("f40_row0", 0, 438, 538);
        check_row("f40_row16", 16, 437, 537);
        check_row("f40_row20", 20, 433, 533);
        check_row("f40_row21", 21, 432, 532);
        check_row("f40_row40", 40, 414, 514);

        repeat (216) frame();
        check_eq("f256_distance", int'(distance), 512);
        check_eq("f256_level", int'(level), 2);
        frame();
        check_eq("f257_distance", int'(distance), 514);
        check_row("lvl2_row0", 0, 423, 519);
        check_row("lvl2_row1", 1, 424, 520);
        check_row("lvl2_row2", 2, 423, 523);

        pause = 1'b1;
        read_row(0, l0, r0);
        repeat (5) frame();
        check_eq("pause_distance", int'(distance), 514);
        check_row("pause_row0", 0, l0, r0);
        check_row("pause_row2", 2, 423, 523);
        pause = 1'b0;

        car_row = 10'd375; car_x_lo = 10'd300; car_x_hi = 10'd310; vCount = 10'd375;
        crash_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (crash) crash_cycles++;
        end
        check_eq("crash_pulse_cycles", crash_cycles, 1);
        check_eq("crash_dead", int'(dead), 1);
        car_row = 10'd1023; car_x_lo = 10'd460; car_x_hi = 10'd470;

        repeat (59) frame();
        check_eq("crash59_dead", int'(dead), 1);
        frame();
        check_eq("crash60_dead", int'(dead), 0);
        check_eq("crash60_distance", int'(distance), 0);
        check_eq("crash60_level", int'(level), 1);
        tick(482);
        sweep_fill("refill_sweep_bad_rows");

        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        @(negedge clk);
        check_eq("midgen_distance", int'(distance), 1);
        rst = 1'b1;
        tick(2);
        check_eq("midgen_rst_distance", int'(distance), 0);
        check_eq("midgen_rst_left", int'(left_edge), 414);
        rst = 1'b0;
        tick(482);
        check_row("post_rst_row0", 0, 414, 514);
        check_row("post_rst_row479", 479, 414, 514);
        check_eq("post_rst_distance", int'(distance), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
